// File: rtl/shreg_fifo_arb_ctrl_pkg.sv
// Shared types and helpers for the shift-register FIFO controller.
// The oldest entry sits at index count-1 of the shift chain.
package shreg_fifo_pkg;

  localparam int DEPTH = 8;

  typedef logic [0:0] req_idx_t;

  function automatic int cnt2pc(input int cnt);
    return (cnt > 0) ? cnt - 1 : 0;
  endfunction

endpackage

// File: rtl/shreg_fifo_arb_ctrl_if.sv
// Write-arbitration and read-handshake bundle between the FIFO controller and its users.
// The master modport is the user side; the slave modport is the controller.
interface shreg_fifo_arb_ctrl_if
  import shreg_fifo_pkg::*;
#(
  parameter int PTR_W = $clog2(shreg_fifo_pkg::DEPTH),
  parameter int CNT_W = $clog2(shreg_fifo_pkg::DEPTH + 1)
);
  logic [1:0]       wr_valid;
  logic [1:0]       wr_grant;
  req_idx_t         wr_sel;
  logic             push_out;
  logic             rd_valid;
  logic             rd_ready;
  logic [PTR_W-1:0] pc;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             flush;

  modport master (
    output wr_valid, rd_ready, flush,
    input  wr_grant, wr_sel, push_out, rd_valid, pc, count,
           full, empty, almost_full, almost_empty
  );

  modport slave (
    input  wr_valid, rd_ready, flush,
    output wr_grant, wr_sel, push_out, rd_valid, pc, count,
           full, empty, almost_full, almost_empty
  );
endinterface

// File: rtl/shreg_fifo_arb_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; winner is combinational, pointer moves only on advance.
// No backpressure of its own: the caller decides when a grant fires.
module rr_arb2
  import shreg_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output req_idx_t   winner,
  output logic       valid
);
  req_idx_t prio_q;

  always_comb begin
    winner = prio_q;
    if (req == 2'b01) winner = 1'b0;
    else if (req == 2'b10) winner = 1'b1;
  end

  assign valid = |req;

  // Pointer names the requester that wins the next tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prio_q <= '0;
    else if (advance) prio_q <= ~winner;
  end
endmodule

// File: rtl/shreg_fifo_arb_ctrl.sv
// Controller for the serial_reg/param_mux FIFO: arbitrates two writers, tracks occupancy and pc.
// Write fires same cycle as grant; when full, a grant needs a same-cycle pop (rd_ready -> wr_grant path).
module shreg_fifo_arb_ctrl #(
  parameter int DEPTH    = shreg_fifo_pkg::DEPTH,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int CNT_W    = $clog2(DEPTH + 1),
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic                 clk,
  input logic                 reset,
  shreg_fifo_arb_ctrl_if.slave bus
);
  import shreg_fifo_pkg::*;

  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [PTR_W-1:0] pc_q;
  logic             full_q, empty_q, af_q, ae_q;
  req_idx_t         winner, sel_q;
  logic             arb_vld, rd_fire, space, push, grant_en;

  assign rd_fire  = !empty_q & bus.rd_ready & !bus.flush;
  assign space    = !full_q | rd_fire;
  assign grant_en = arb_vld & space & !bus.flush & reset;

  assign bus.wr_grant = grant_en ? (2'b01 << winner) : 2'b00;
  assign push         = |(bus.wr_valid & bus.wr_grant);
  assign bus.push_out = push;
  // Hold the source select when idle so the D_in mux does not toggle.
  assign bus.wr_sel   = arb_vld ? winner : sel_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.wr_valid),
    .advance (push),
    .winner  (winner),
    .valid   (arb_vld)
  );

  always_comb begin
    cnt_nxt = cnt_q;
    if (bus.flush) begin
      cnt_nxt = '0;
    end else begin
      case ({push, rd_fire})
        2'b10:   cnt_nxt = cnt_q + 1'b1;
        2'b01:   cnt_nxt = cnt_q - 1'b1;
        default: cnt_nxt = cnt_q;
      endcase
    end
  end

  // Flags and pc come from the next count so they move on the same edge as count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      pc_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      sel_q   <= '0;
    end else begin
      cnt_q   <= cnt_nxt;
      pc_q    <= PTR_W'(cnt2pc(int'(cnt_nxt)));
      full_q  <= (cnt_nxt == CNT_W'(DEPTH));
      empty_q <= (cnt_nxt == '0);
      af_q    <= (cnt_nxt >= CNT_W'(AF_LEVEL));
      ae_q    <= (cnt_nxt <= CNT_W'(AE_LEVEL));
      sel_q   <= bus.wr_sel;
    end
  end

  assign bus.count        = cnt_q;
  assign bus.pc           = pc_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.rd_valid     = !empty_q;

  a_legal_state: assert property (@(posedge clk) disable iff (!reset)
    (cnt_q <= CNT_W'(DEPTH)) && $onehot0(bus.wr_grant));
endmodule

// File: tb/tb_shreg_fifo_arb_ctrl.sv
// Directed bench for shreg_fifo_arb_ctrl with a behavioural serial_reg/param_mux model.
module tb_shreg_fifo_arb_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] d0, d1;
  logic [3:0] ent [0:7];
  logic [3:0] mux_out;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shreg_fifo_arb_ctrl_if #(.PTR_W(3), .CNT_W(4)) bus ();

  shreg_fifo_arb_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Datapath model: shift on push_out, D_in steered by wr_sel, read at pc.
  always @(posedge clk) begin
    if (bus.push_out) begin
      for (int k = 7; k > 0; k--) ent[k] <= ent[k-1];
      ent[0] <= bus.wr_sel[0] ? d1 : d0;
    end
  end
  assign mux_out = ent[bus.pc];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    bus.wr_valid = 2'b11;
    bus.rd_ready = 1'b0;
    bus.flush = 1'b0;
    d0 = 4'd0;
    d1 = 4'd0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_ae", 32'(bus.almost_empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_af", 32'(bus.almost_full), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_grant", 32'(bus.wr_grant), 0);

    // Reset mid-fill
    @(negedge clk);
    reset = 1'b1;
    bus.wr_valid = 2'b01;
    repeat (3) tick();
    chk("pre_rst_count", 32'(bus.count), 3);
    reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.count), 0);
    chk("async_rst_pc", 32'(bus.pc), 0);
    chk("async_rst_empty", 32'(bus.empty), 1);
    chk("async_rst_grant", 32'(bus.wr_grant), 0);
    @(negedge clk);
    reset = 1'b1;
    bus.wr_valid = 2'b00;

    // Single requester fills the FIFO
    for (int k = 1; k <= 8; k++) begin
      bus.wr_valid = 2'b01;
      d0 = 4'(k);
      #1;
      chk("fill_grant", 32'(bus.wr_grant), 1);
      chk("fill_push", 32'(bus.push_out), 1);
      chk("fill_sel", 32'(bus.wr_sel), 0);
      tick();
      chk("fill_count", 32'(bus.count), 32'(k));
      chk("fill_pc", 32'(bus.pc), 32'(k - 1));
      chk("fill_af", 32'(bus.almost_full), 32'(k >= 6));
      chk("fill_full", 32'(bus.full), 32'(k == 8));
      chk("fill_rd_valid", 32'(bus.rd_valid), 1);
    end
    #1;
    chk("full_no_grant", 32'(bus.wr_grant), 0);
    chk("full_no_push", 32'(bus.push_out), 0);
    tick();
    chk("full_hold_count", 32'(bus.count), 8);

    // Full with push and pop together
    bus.wr_valid = 2'b10;
    d1 = 4'd9;
    bus.rd_ready = 1'b1;
    #1;
    chk("pp_grant", 32'(bus.wr_grant), 2);
    chk("pp_push", 32'(bus.push_out), 1);
    chk("pp_oldest", 32'(mux_out), 1);
    tick();
    chk("pp_count", 32'(bus.count), 8);
    chk("pp_pc", 32'(bus.pc), 7);
    chk("pp_full", 32'(bus.full), 1);

    // Drain in order
    bus.wr_valid = 2'b00;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("drain_rd_valid", 32'(bus.rd_valid), 1);
      chk("drain_pc", 32'(bus.pc), 32'(7 - j));
      chk("drain_data", 32'(mux_out), 32'(2 + j));
      tick();
      chk("drain_count", 32'(bus.count), 32'(7 - j));
      chk("drain_ae", 32'(bus.almost_empty), 32'((7 - j) <= 2));
      chk("drain_empty", 32'(bus.empty), 32'(j == 7));
    end
    chk("empty_rd_valid", 32'(bus.rd_valid), 0);
    tick();
    chk("empty_no_underflow", 32'(bus.count), 0);
    chk("empty_pc", 32'(bus.pc), 0);

    // Round-robin on a tie
    bus.rd_ready = 1'b0;
    bus.wr_valid = 2'b11;
    d0 = 4'd10;
    d1 = 4'd11;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_grant", 32'(bus.wr_grant), (i % 2 == 0) ? 1 : 2);
      chk("rr_sel", 32'(bus.wr_sel), 32'(i % 2));
      tick();
    end
    chk("rr_count", 32'(bus.count), 6);
    chk("rr_af", 32'(bus.almost_full), 1);

    // Idle write side holds wr_sel while a pop happens
    bus.wr_valid = 2'b00;
    bus.rd_ready = 1'b1;
    #1;
    chk("sel_hold", 32'(bus.wr_sel), 1);
    tick();
    chk("pop_count", 32'(bus.count), 5);

    // Requester 0 alone, push and pop together below full
    bus.wr_valid = 2'b01;
    #1;
    chk("pp_mid_grant", 32'(bus.wr_grant), 1);
    tick();
    chk("pp_mid_count", 32'(bus.count), 5);
    chk("pp_mid_pc", 32'(bus.pc), 4);

    // Flush
    bus.wr_valid = 2'b11;
    bus.flush = 1'b1;
    #1;
    chk("flush_grant", 32'(bus.wr_grant), 0);
    chk("flush_push", 32'(bus.push_out), 0);
    tick();
    bus.flush = 1'b0;
    bus.rd_ready = 1'b0;
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_pc", 32'(bus.pc), 0);
    chk("flush_empty", 32'(bus.empty), 1);
    chk("flush_ae", 32'(bus.almost_empty), 1);
    chk("flush_af", 32'(bus.almost_full), 0);
    chk("flush_rd_valid", 32'(bus.rd_valid), 0);

    // Pointer survives flush: requester 0 won last, so requester 1 takes the tie
    #1;
    chk("post_flush_grant", 32'(bus.wr_grant), 2);
    chk("post_flush_sel", 32'(bus.wr_sel), 1);
    tick();
    chk("post_flush_count", 32'(bus.count), 1);
    chk("post_flush_pc", 32'(bus.pc), 0);
    bus.wr_valid = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shreg_fifo_arb_ctrl.md
Name: shreg_fifo_arb_ctrl

Overview:
- Controller and 2-requester round-robin write arbiter for the shift-register FIFO datapath: serial_reg (8 x 4-bit shift chain) plus param_mux (entry select by pc).
- Generates the shift strobe (push_out), the read select pc, the write-source select and occupancy flags.
- Exposes a valid/ready handshake on both sides.
- Replaces ad-hoc push/pop driving of the datapath; the datapath itself is unchanged.

Parameters:
- DEPTH, 8, number of shift-register entries.
- PTR_W, $clog2(DEPTH), width of pc.
- CNT_W, $clog2(DEPTH+1), width of count.
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  2  per-requester write request; bit i is requester i.
- wr_grant  out  2  one-hot accept; wr_valid[i] & wr_grant[i] = write fire for requester i.
- wr_sel  out  1  index of the granted requester; steers the datapath D_in mux.
- push_out  out  1  shift enable to serial_reg; equals any write fire.
- rd_valid  out  1  oldest entry available at the param_mux output.
- rd_ready  in  1  consumer takes the entry.
- pc  out  PTR_W  param_mux select, addresses the oldest entry.
- count  out  CNT_W  current occupancy.
- full, empty, almost_full, almost_empty  out  1 each  registered flags.
- flush  in  1  synchronous: discard all entries.

Behaviour:
- Reset (reset=0, asynchronous): count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, pc=0, RR pointer=0 (requester 0 has priority). wr_grant=0 while reset is asserted.
- Datapath model: each push shifts entry[k] to entry[k+1] and loads entry[0]. The oldest entry is therefore at index count-1.
- pc = count-1 when count>0, else 0. pc is registered and changes on the same edge as count.
- rd_valid = !empty. rd_fire = rd_valid & rd_ready.
- Write admission: space = !full | rd_fire. rd_fire is combinational, so the path rd_ready->wr_grant is allowed and documented.
- Arbitration (rr_arb2):
  - One requester valid: it wins.
  - Both valid: the requester other than the last winner wins.
  - RR pointer updates only on a write fire.
  - wr_grant[w] = wr_valid[w] & space & !flush, where w is the winner. wr_grant is combinational.
- wr_sel = w whenever any wr_valid is high. Otherwise wr_sel holds its last value (registered hold, no toggling).
- push_out = |(wr_valid & wr_grant). At most one bit is set.
- Count update, one per edge:
  - push only: +1; pc increments.
  - pop only: -1; pc decrements.
  - push and pop together: count and pc unchanged. The shift moves the next-oldest entry into pc's slot.
  - neither: hold.
- Latency: a write firing at edge N makes rd_valid=1 after edge N (empty FIFO). Data is visible at param_mux after the same edge.
- Full (count==DEPTH):
  - No grant unless rd_fire.
  - Push and pop together keep count=DEPTH.
- Empty:
  - rd_fire is impossible.
  - A write proceeds normally. There is no fall-through within the same cycle.
- Flush:
  - Next edge: count=0, pc=0, flags = reset values.
  - No grant during flush; any rd_ready is ignored.
  - RR pointer is kept.
- Flags are derived from the next count and registered; they are never combinational off count.
- Reset asserted mid-operation: immediate return to the reset state. Any in-flight fire is lost.
- Illegal states are unreachable. An assertion checks count <= DEPTH and onehot0(wr_grant).

Decomposition:
- Package shreg_fifo_pkg:
  - DEPTH default localparam.
  - req_idx_t (logic [0:0]).
  - Helper function cnt2pc(count) returning pc.
- Sub-module rr_arb2:
  - Inputs: clk, reset, req[1:0], advance.
  - Outputs: winner, valid.
  - Holds the RR pointer.
- Top module holds the count/pc/flag registers and the glue logic.

Test Plan:
- Reset mid-fill: push 3 entries, assert reset=0 -> count=0, pc=0, empty=1 immediately, without waiting for clk.
- Single requester fills the FIFO: wr_valid=01 for 8 cycles with D_in=1..8, rd_ready=0.
  - pc steps 0..7; count=8; full=1.
  - almost_full rises when count reaches 6.
  - The 9th request sees wr_grant=00.
- Round-robin: both requesters hold valid for 6 cycles -> grants alternate 01,10,01,10,01,10. wr_sel tracks the grant each cycle.
- Full with push and pop together: count=8, wr_valid=10, rd_ready=1 -> grant=10, push_out=1, count stays 8, pc stays 7. The popped value is the oldest (1).
- Drain order: after the fill, rd_ready=1 for 8 cycles -> param_mux outputs 1,2,...,8 in order, pc goes 7 down to 0. Then empty=1, rd_valid=0, almost_empty at count<=2.
- Flush: count=5, flush=1 for 1 cycle with wr_valid=11 -> no grant; after the edge count=0, pc=0, empty=1. The RR pointer is preserved: the next tie is won by the requester that did not win last.
